fetch_stage: RTL and testbench

Instruction-fetch stage and F/D pipeline register of the five-stage MIPS core.
- Drives the PC, runs a req/ready handshake with a variable-latency instruction memory, and applies D-stage redirects with MIPS delay-slot semantics.
- Presents the fetched instruction, its PC and PC+8 to the decode stage, whose control-unit decoder consumes d_instr directly.
- Honours the hazard unit's stall with a one-entry buffer, so completed fetches are never lost.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_skid_buf.sv | 26 ++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants and types for the instruction-fetch stage
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;
    localparam logic [31:0] LINK_OFFSET   = 32'd8;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_skid_buf.sv
// rtl/fetch_stage_skid_buf.sv - one-entry {instr, pc} buffer catching a fetch that completes under stall
module if_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  fetch_entry_t load_entry,
    input  logic         drain,
    output logic         full,
    output fetch_entry_t entry
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= load_entry;
        end else if (drain) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, imem handshake, delay-slot redirects and the F/D pipeline register
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_valid
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic         pend_q;
    logic [31:0]  pend_pc_q;
    logic [31:0]  d_instr_q;
    logic [31:0]  d_pc_q;
    logic         d_valid_q;

    logic         fire;
    logic         redir;
    logic [31:0]  next_pc;
    logic         buf_load;
    logic         buf_drain;
    logic         buf_full;
    fetch_entry_t buf_entry;

    // Gating with reset drops the request the instant reset asserts, mid-handshake included.
    assign imem_req  = (state_q == ST_FETCH) && reset;
    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_ready;
    assign redir     = redirect_valid && !stall;

    always_comb begin
        next_pc = pc_q + PC_INC;
        if (redir) begin
            next_pc = redirect_pc;
        end else if (pend_q) begin
            next_pc = pend_pc_q;
        end
    end

    assign buf_load  = fire && stall;
    assign buf_drain = (state_q == ST_HOLD) && buf_full && !stall;

    if_skid_buf u_skid_buf (
        .clk        (clk),
        .rst_n      (reset),
        .load       (buf_load),
        .load_entry ('{instr: imem_rdata, pc: pc_q}),
        .drain      (buf_drain),
        .full       (buf_full),
        .entry      (buf_entry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            d_instr_q <= NOP_INSTR;
            d_pc_q    <= '0;
            d_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (fire) begin
                        pc_q   <= next_pc;
                        pend_q <= 1'b0;
                        if (stall) begin
                            state_q <= ST_HOLD;
                        end else begin
                            d_instr_q <= imem_rdata;
                            d_pc_q    <= pc_q;
                            d_valid_q <= 1'b1;
                        end
                    end else begin
                        // The in-flight fetch is the delay slot; remember the target for its completion.
                        if (redir) begin
                            pend_q    <= 1'b1;
                            pend_pc_q <= redirect_pc;
                        end
                        if (!stall) begin
                            d_instr_q <= NOP_INSTR;
                            d_valid_q <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (buf_drain) begin
                        d_instr_q <= buf_entry.instr;
                        d_pc_q    <= buf_entry.pc;
                        d_valid_q <= 1'b1;
                        state_q   <= ST_FETCH;
                        // The buffered word is the delay slot, so the target is the very next fetch.
                        if (redir) begin
                            pc_q <= redirect_pc;
                        end
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign d_instr = d_instr_q;
    assign d_pc    = d_pc_q;
    assign d_valid = d_valid_q;
    assign d_pc8   = d_pc_q + LINK_OFFSET;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a program-order reference model
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc8;
    logic        d_valid;

    int n_checks = 0;
    int n_pass = 0;
    int deliveries = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .d_instr        (d_instr),
        .d_pc           (d_pc),
        .d_pc8          (d_pc8),
        .d_valid        (d_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Program-order stream still owed to D: [0] is the next real instruction, [1] the one after it.
    logic [31:0] exp_q[$];
    logic [31:0] prev_instr, prev_pc, prev_addr;
    logic        prev_valid, prev_req;

    always begin
        @(posedge clk);
        #1;
        if (!reset) begin
            exp_q = {};
            exp_q.push_back(RST_PC);
            exp_q.push_back(RST_PC + 32'd4);
            prev_instr = NOP;
            prev_pc    = '0;
            prev_valid = 1'b0;
            prev_req   = 1'b0;
            prev_addr  = '0;
        end else begin
            if (redirect_valid && !stall) begin
                while (exp_q.size() > 1) void'(exp_q.pop_back());
                exp_q.push_back(redirect_pc);
            end
            if (stall) begin
                chk("hold_instr", d_instr, prev_instr);
                chk("hold_pc", d_pc, prev_pc);
                chk("hold_valid", {31'd0, d_valid}, {31'd0, prev_valid});
            end else if (d_valid) begin
                chk("deliver_pc", d_pc, exp_q[0]);
                chk("deliver_instr", d_instr, mem_word(exp_q[0]));
                chk("deliver_pc8", d_pc8, exp_q[0] + 32'd8);
                void'(exp_q.pop_front());
                exp_q.push_back(exp_q[0] + 32'd4);
                deliveries++;
            end else begin
                chk("bubble_instr", d_instr, NOP);
                chk("bubble_pc", d_pc, prev_pc);
            end
            if (prev_req && !imem_ready) begin
                chk("req_held", {31'd0, imem_req}, 32'd1);
                chk("addr_stable", imem_addr, prev_addr);
            end
            prev_instr = d_instr;
            prev_pc    = d_pc;
            prev_valid = d_valid;
            prev_req   = imem_req;
            prev_addr  = imem_addr;
        end
    end

    task automatic drive(input logic st, input logic rdy, input logic rv, input logic [31:0] rpc);
        stall          = st;
        imem_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, d_valid}, 32'd0);
        chk("rst_pc", d_pc, 32'd0);
        chk("rst_instr", d_instr, NOP);
        tick();
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, '0);
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h3000);
        tick();
        chk("seq_addr1", imem_addr, 32'h3004);
        chk("seq_dpc0", d_pc, 32'h3000);
        chk("seq_pc8", d_pc8, 32'h3008);
        drive(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_addr", imem_addr, 32'h3004);
            chk("wait_bubble", {31'd0, d_valid}, 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, '0);
        tick();
        chk("wait_done_pc", d_pc, 32'h3004);
        chk("wait_done_addr", imem_addr, 32'h3008);
        drive(1'b0, 1'b1, 1'b1, 32'h3100);
        tick();
        chk("dslot_pc", d_pc, 32'h3008);
        chk("target_addr", imem_addr, 32'h3100);
        drive(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_dpc", d_pc, 32'h3008);
            chk("no_300c", {31'd0, imem_addr == 32'h300C}, 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, '0);
        tick();
        chk("drain_pc", d_pc, 32'h3100);
        chk("drain_valid", {31'd0, d_valid}, 32'd1);
        chk("resume_addr", imem_addr, 32'h3104);
        drive(1'b0, 1'b0, 1'b1, 32'h3200);
        tick();
        chk("pend_addr", imem_addr, 32'h3104);
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        chk("pend_addr2", imem_addr, 32'h3104);
        drive(1'b0, 1'b1, 1'b0, '0);
        tick();
        chk("pend_dslot", d_pc, 32'h3104);
        chk("pend_target", imem_addr, 32'h3200);
        drive(1'b1, 1'b0, 1'b0, '0);
        tick();
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, d_valid}, 32'd0);
        chk("mid_rst_instr", d_instr, NOP);
        tick();
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, '0);
        #1;
        chk("restart_addr", imem_addr, 32'h3000);
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < 3000; i++) begin
            tick();
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 9) == 0),
                  32'h0000_4000 + ($urandom_range(0, 255) << 2));
        end
        drive(1'b0, 1'b1, 1'b0, '0);
        tick();
        tick();
        chk("enough_deliveries", {31'd0, deliveries >= 500}, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
